// File: rtl/membus_pkg.sv
// Shared definitions for the PDP-6 membus master: op codes, FSM states
// and the membus address field ranges.
package membus_pkg;

    localparam logic [1:0] OP_NONE = 2'd0;
    localparam logic [1:0] OP_RD   = 2'd1;
    localparam logic [1:0] OP_WR   = 2'd2;
    localparam logic [1:0] OP_RMW  = 2'd3;

    // RMW sets both bits, so each bit directly drives its membus request line.
    localparam int OP_RD_BIT = 0;
    localparam int OP_WR_BIT = 1;

    // sel and ma share bit 21 of the address.
    localparam int SEL_LO = 18;
    localparam int SEL_HI = 21;
    localparam int MA_LO  = 21;
    localparam int MA_HI  = 35;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        RD    = 3'd2,
        MOD   = 3'd3,
        WSET  = 3'd4,
        WRS   = 3'd5,
        WHOLD = 3'd6
    } state_t;

endpackage

// File: rtl/membus_edge.sv
// Rising-edge detector: remembers last cycle's level so a held-high
// membus acknowledge is seen exactly once.
module membus_edge (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic prev_q;

    always_ff @(posedge clk) begin
        if (reset) prev_q <= 1'b0;
        else       prev_q <= level;
    end

    assign rise = level & ~prev_q;

endmodule

// File: rtl/membus_master.sv
// Processor-side PDP-6 membus master: runs one RD, WR or RMW cycle per
// request, with registered bus outputs and a timeout for missing memory.
module membus_master
    import membus_pkg::*;
#(
    parameter int TIMEOUT  = 1000,
    parameter int WR_SETUP = 2,
    parameter int WR_HOLD  = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic [1:0]    req_op,
    input  logic          req_fmc,
    input  logic [18:35]  req_addr,
    input  logic [0:35]   req_wdata,
    input  logic          mod_valid,
    input  logic [0:35]   mod_data,
    output logic          busy,
    output logic [0:35]   rd_data,
    output logic          rd_done,
    output logic          done,
    output logic          err,
    output logic          membus_rq_cyc,
    output logic          membus_rd_rq,
    output logic          membus_wr_rq,
    output logic [18:21]  membus_sel,
    output logic [21:35]  membus_ma,
    output logic          membus_fmc_select,
    output logic [0:35]   membus_mb_out,
    output logic          membus_wr_rs,
    input  logic          membus_addr_ack,
    input  logic          membus_rd_rs,
    input  logic [0:35]   membus_mb_in,
    output state_t        dbg_state
);

    localparam int CNT_MAX = (TIMEOUT > WR_SETUP) ? ((TIMEOUT > WR_HOLD) ? TIMEOUT : WR_HOLD)
                                                  : ((WR_SETUP > WR_HOLD) ? WR_SETUP : WR_HOLD);
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(WR_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(WR_HOLD - 1);

    // Requester handshake: req with a nonzero req_op is taken only while
    // busy=0; the transaction ends with a one-cycle done (busy still 1 that
    // cycle, 0 the next), so the earliest next request is the cycle after done.

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [0:35]        wword_q, wword_d;
    logic [0:35]        rd_data_d, mb_out_d;
    logic [18:21]       sel_d;
    logic [21:35]       ma_d;
    logic               busy_d, done_d, rd_done_d, err_d;
    logic               rq_cyc_d, rd_rq_d, wr_rq_d, fmc_d, wr_rs_d;
    logic               ack_rise, rd_rise;

    membus_edge u_ack_edge (.clk(clk), .reset(reset), .level(membus_addr_ack), .rise(ack_rise));
    membus_edge u_rd_edge  (.clk(clk), .reset(reset), .level(membus_rd_rs),    .rise(rd_rise));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        op_d      = op_q;
        wword_d   = wword_q;
        rd_data_d = rd_data;
        busy_d    = 1'b1;
        done_d    = 1'b0;
        rd_done_d = 1'b0;
        err_d     = 1'b0;
        rq_cyc_d  = membus_rq_cyc;
        rd_rq_d   = membus_rd_rq;
        wr_rq_d   = membus_wr_rq;
        sel_d     = membus_sel;
        ma_d      = membus_ma;
        fmc_d     = membus_fmc_select;
        mb_out_d  = membus_mb_out;
        wr_rs_d   = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                cnt_d  = '0;
                if (req && req_op != OP_NONE && !busy) begin
                    state_d   = ADDR;
                    op_d      = req_op;
                    wword_d   = req_wdata;
                    rd_data_d = '0;
                    busy_d    = 1'b1;
                    rq_cyc_d  = 1'b1;
                    rd_rq_d   = req_op[OP_RD_BIT];
                    wr_rq_d   = req_op[OP_WR_BIT];
                    sel_d     = req_addr[SEL_LO:SEL_HI];
                    ma_d      = req_addr[MA_LO:MA_HI];
                    fmc_d     = req_fmc;
                end
            end
            ADDR: begin
                if (ack_rise) begin
                    // Request lines drop now; sel/ma/fmc stay one more cycle.
                    rq_cyc_d = 1'b0;
                    rd_rq_d  = 1'b0;
                    wr_rq_d  = 1'b0;
                    cnt_d    = '0;
                    if (op_q[OP_RD_BIT]) begin
                        state_d   = RD;
                        rd_data_d = rd_data | membus_mb_in;
                    end else begin
                        state_d  = WSET;
                        mb_out_d = wword_q;
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d  = IDLE;
                    rq_cyc_d = 1'b0;
                    rd_rq_d  = 1'b0;
                    wr_rq_d  = 1'b0;
                    sel_d    = '0;
                    ma_d     = '0;
                    fmc_d    = 1'b0;
                    done_d   = 1'b1;
                    err_d    = 1'b1;
                end
            end
            RD: begin
                sel_d     = '0;
                ma_d      = '0;
                fmc_d     = 1'b0;
                rd_data_d = rd_data | membus_mb_in;
                if (rd_rise) begin
                    rd_done_d = 1'b1;
                    cnt_d     = '0;
                    if (op_q[OP_WR_BIT]) begin
                        state_d = MOD;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            MOD: begin
                // Memory is stalled awaiting wr_rs, so no timeout applies.
                cnt_d = '0;
                if (mod_valid) begin
                    state_d  = WSET;
                    wword_d  = mod_data;
                    mb_out_d = mod_data;
                end
            end
            WSET: begin
                sel_d = '0;
                ma_d  = '0;
                fmc_d = 1'b0;
                if (cnt_q == SETUP_LAST) begin
                    state_d = WRS;
                    wr_rs_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            WRS: begin
                state_d = WHOLD;
                cnt_d   = '0;
            end
            WHOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d  = IDLE;
                    mb_out_d = '0;
                    done_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= IDLE;
            cnt_q             <= '0;
            op_q              <= OP_NONE;
            wword_q           <= '0;
            rd_data           <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            rd_done           <= 1'b0;
            err               <= 1'b0;
            membus_rq_cyc     <= 1'b0;
            membus_rd_rq      <= 1'b0;
            membus_wr_rq      <= 1'b0;
            membus_sel        <= '0;
            membus_ma         <= '0;
            membus_fmc_select <= 1'b0;
            membus_mb_out     <= '0;
            membus_wr_rs      <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            op_q              <= op_d;
            wword_q           <= wword_d;
            rd_data           <= rd_data_d;
            busy              <= busy_d;
            done              <= done_d;
            rd_done           <= rd_done_d;
            err               <= err_d;
            membus_rq_cyc     <= rq_cyc_d;
            membus_rd_rq      <= rd_rq_d;
            membus_wr_rq      <= wr_rq_d;
            membus_sel        <= sel_d;
            membus_ma         <= ma_d;
            membus_fmc_select <= fmc_d;
            membus_mb_out     <= mb_out_d;
            membus_wr_rs      <= wr_rs_d;
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_membus_master.sv
// Bench for membus_master: a core memory model answers the membus, a
// scoreboard queues expected results and a monitor checks each done/rd_done.
module tb_membus_master;
    import membus_pkg::*;

    localparam int TIMEOUT  = 1000;
    localparam int WR_SETUP = 2;
    localparam int WR_HOLD  = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          req;
    logic [1:0]    req_op;
    logic          req_fmc;
    logic [18:35]  req_addr;
    logic [0:35]   req_wdata;
    logic          mod_valid;
    logic [0:35]   mod_data;
    logic          busy, rd_done, done, err;
    logic [0:35]   rd_data;
    logic          membus_rq_cyc, membus_rd_rq, membus_wr_rq;
    logic [18:21]  membus_sel;
    logic [21:35]  membus_ma;
    logic          membus_fmc_select;
    logic [0:35]   membus_mb_out;
    logic          membus_wr_rs;
    logic          membus_addr_ack;
    logic          membus_rd_rs;
    logic [0:35]   membus_mb_in;
    state_t        dbg_state;

    membus_master #(.TIMEOUT(TIMEOUT), .WR_SETUP(WR_SETUP), .WR_HOLD(WR_HOLD)) dut (
        .clk(clk), .reset(reset), .req(req), .req_op(req_op), .req_fmc(req_fmc),
        .req_addr(req_addr), .req_wdata(req_wdata), .mod_valid(mod_valid), .mod_data(mod_data),
        .busy(busy), .rd_data(rd_data), .rd_done(rd_done), .done(done), .err(err),
        .membus_rq_cyc(membus_rq_cyc), .membus_rd_rq(membus_rd_rq), .membus_wr_rq(membus_wr_rq),
        .membus_sel(membus_sel), .membus_ma(membus_ma), .membus_fmc_select(membus_fmc_select),
        .membus_mb_out(membus_mb_out), .membus_wr_rs(membus_wr_rs),
        .membus_addr_ack(membus_addr_ack), .membus_rd_rs(membus_rd_rs),
        .membus_mb_in(membus_mb_in), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          failures = 0;
    logic [36:0] exp_q[$];      // {err, rd_data} expected at done
    logic [35:0] exp_rd_q[$];   // rd_data expected at rd_done
    bit          expect_timeout = 1'b0;
    int          wr_rs_count = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0o required=%0o", name, act, exp);
        end
    endtask

    // ---------------- core memory model ----------------
    logic [0:35] mem [0:32767];
    logic [3:0]  model_sel = 4'd0;
    bit          early_data = 1'b0;
    logic [0:14] last_ma;
    logic        last_fmc;
    int          txn_count = 0;

    task automatic serve();
        logic [0:14] a;
        logic        r, w;
        logic [0:35] word;
        bit          got;
        a = membus_ma;
        r = membus_rd_rq;
        w = membus_wr_rq;
        last_ma  = a;
        last_fmc = membus_fmc_select;
        txn_count++;
        word = mem[a];
        @(negedge clk);
        @(negedge clk);
        membus_addr_ack = 1'b1;
        for (int i = 0; i < 20 && membus_rq_cyc; i++) @(negedge clk);
        membus_addr_ack = 1'b0;
        if (r) begin
            @(negedge clk);
            membus_mb_in = word;
            if (early_data) begin
                @(negedge clk);
                membus_mb_in = '0;
            end
            membus_rd_rs = 1'b1;
            @(negedge clk);
            membus_mb_in = '0;
            @(negedge clk);
            membus_rd_rs = 1'b0;
        end
        if (w) begin
            mem[a] = '0;
            got = 1'b0;
            for (int i = 0; i < 3000 && !got && !reset; i++) begin
                if (membus_wr_rs) begin
                    mem[a] = membus_mb_out;
                    got = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
            if (!got && !reset) begin
                checks++;
                failures++;
                $display("FAIL mem_wr_rs_wait actual=no_wr_rs required=wr_rs");
            end
        end
    endtask

    initial begin : mem_model
        membus_addr_ack = 1'b0;
        membus_rd_rs    = 1'b0;
        membus_mb_in    = '0;
        forever begin
            @(negedge clk);
            if (!reset && membus_rq_cyc && membus_sel == model_sel) serve();
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        int          rq_run;
        int          mb_stable;
        logic [0:35] mb_prev;
        logic        wr_rs_prev;
        logic [36:0] e;
        logic [35:0] er;
        rq_run = 0;
        mb_stable = 0;
        mb_prev = '0;
        wr_rs_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (done) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done actual=done rd_data=%0o err=%0b required=no_done", rd_data, err);
                    end else begin
                        e = exp_q.pop_front();
                        check("done_err_rd_data", {err, rd_data}, e);
                        check("busy_at_done", busy, 1);
                        check("mb_out_zero_at_done", membus_mb_out, 0);
                    end
                end
                if (rd_done) begin
                    if (exp_rd_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_rd_done actual=rd_done required=none");
                    end else begin
                        er = exp_rd_q.pop_front();
                        check("rd_done_data", rd_data, er);
                        check("busy_at_rd_done", busy, 1);
                    end
                end
                if (membus_rq_cyc) begin
                    rq_run++;
                end else begin
                    if (rq_run > 0 && expect_timeout) begin
                        check("timeout_rq_cyc_cycles", rq_run, TIMEOUT);
                        expect_timeout = 1'b0;
                    end
                    rq_run = 0;
                end
                if (membus_mb_out == mb_prev) mb_stable++;
                else mb_stable = 1;
                mb_prev = membus_mb_out;
                if (membus_wr_rs) begin
                    wr_rs_count++;
                    check("wr_setup_stable", (mb_stable - 1) >= WR_SETUP, 1);
                    check("wr_rs_single_cycle", wr_rs_prev, 0);
                end
            end
            wr_rs_prev = membus_wr_rs;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [1:0] op, input logic [18:35] addr,
                         input logic [0:35] wdata, input logic fmc);
        req       = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        req_fmc   = fmc;
        @(negedge clk);
        req    = 1'b0;
        req_op = OP_NONE;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0 || exp_rd_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_completes"}, n < 3000, 1);
    endtask

    task automatic expect_read(input logic [0:35] data);
        exp_rd_q.push_back(data);
        exp_q.push_back({1'b0, data});
    endtask

    // ---------------- stimulus ----------------
    initial begin : stimulus
        int n;
        int wr_before;
        reset     = 1'b1;
        req       = 1'b0;
        req_op    = OP_NONE;
        req_fmc   = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        mod_valid = 1'b0;
        mod_data  = '0;
        mem[15'o123] = 36'o123456654321;
        mem[15'o10]  = 36'o5;
        mem[15'o200] = 36'o42;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_rq_cyc", membus_rq_cyc, 0);
        check("reset_rd_data", rd_data, 0);
        check("reset_mb_out", membus_mb_out, 0);
        check("reset_done", {done, rd_done, err, membus_wr_rs}, 0);
        check("reset_state", dbg_state, IDLE);
        reset = 1'b0;
        @(negedge clk);

        // Plain read
        expect_read(36'o123456654321);
        issue(OP_RD, 18'o000123, '0, 1'b0);
        check("rd_rq_cyc", {membus_rq_cyc, membus_rd_rq, membus_wr_rq}, 3'b110);
        check("rd_sel_ma", {membus_sel, membus_ma}, {4'd0, 15'o123});
        wait_idle("rd_123");
        check("rd_model_ma", last_ma, 15'o123);

        // Write, with a stray request while busy that must be ignored
        wr_before = txn_count;
        exp_q.push_back({1'b0, 36'o0});
        issue(OP_WR, 18'o000777, 36'o777000000777, 1'b0);
        check("wr_rq_lines", {membus_rq_cyc, membus_rd_rq, membus_wr_rq}, 3'b101);
        repeat (2) @(negedge clk);
        issue(OP_RD, 18'o000123, '0, 1'b0);
        wait_idle("wr_777");
        repeat (3) @(negedge clk);
        check("wr_single_txn", txn_count - wr_before, 1);
        check("wr_rs_pulses", wr_rs_count, 1);
        check("wr_mem_word", mem[15'o777], 36'o777000000777);
        expect_read(36'o777000000777);
        issue(OP_RD, 18'o000777, '0, 1'b0);
        wait_idle("rd_777");

        // Read-modify-write with a slow modifier
        exp_rd_q.push_back(36'o5);
        exp_q.push_back({1'b0, 36'o5});
        issue(OP_RMW, 18'o000010, '0, 1'b0);
        n = 0;
        while (!rd_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rmw_rd_done_seen", n < 200, 1);
        repeat (50) @(negedge clk);
        check("rmw_stalled_state", {busy, membus_wr_rs, dbg_state}, {1'b1, 1'b0, MOD});
        check("rmw_mem_stalled", mem[15'o10], 36'o0);
        mod_data  = 36'o6;
        mod_valid = 1'b1;
        @(negedge clk);
        mod_valid = 1'b0;
        mod_data  = '0;
        wait_idle("rmw_10");
        repeat (3) @(negedge clk);
        expect_read(36'o6);
        issue(OP_RD, 18'o000010, '0, 1'b0);
        wait_idle("rd_10");

        // Non-existent memory: timeout, then a normal request
        model_sel = 4'd7;
        expect_timeout = 1'b1;
        exp_q.push_back({1'b1, 36'o0});
        issue(OP_RD, 18'o000123, '0, 1'b0);
        wait_idle("timeout");
        check("timeout_measured", expect_timeout, 0);
        check("timeout_busy_after", busy, 0);
        model_sel = 4'd0;
        expect_read(36'o123456654321);
        issue(OP_RD, 18'o000123, '0, 1'b0);
        wait_idle("rd_after_timeout");

        // Read data arriving one cycle ahead of rd_rs, on fast memory
        early_data = 1'b1;
        expect_read(36'o42);
        issue(OP_RD, 18'o000200, '0, 1'b1);
        check("fmc_select_driven", membus_fmc_select, 1);
        wait_idle("rd_early");
        early_data = 1'b0;
        check("fmc_model_seen", last_fmc, 1);

        // Reset in the middle of a write setup
        issue(OP_WR, 18'o000050, 36'o1, 1'b0);
        n = 0;
        while (membus_mb_out == '0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reset_test_reached_wset", dbg_state, WSET);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_bus_lines",
              {membus_rq_cyc, membus_rd_rq, membus_wr_rq, membus_wr_rs, membus_fmc_select}, 0);
        check("midreset_mb_out", membus_mb_out, 0);
        check("midreset_sel_ma", {membus_sel, membus_ma}, 0);
        check("midreset_busy_done", {busy, done, rd_done, err}, 0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("after_reset_state", dbg_state, IDLE);
        check("after_reset_queues", exp_q.size() + exp_rd_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
